// File: rtl/riscv_mpsoc_pkg.sv
// rtl/riscv_mpsoc_pkg.sv - shared PMA constants, config layout and arbiter state encoding
package riscv_mpsoc_pkg;

  localparam logic [1:0] MEM_TYPE_EMPTY = 2'b00;
  localparam logic [1:0] MEM_TYPE_MAIN  = 2'b01;
  localparam logic [1:0] MEM_TYPE_IO    = 2'b10;
  localparam logic [1:0] MEM_TYPE_TCM   = 2'b11;

  localparam logic [1:0] OFF   = 2'd0;
  localparam logic [1:0] TOR   = 2'd1;
  localparam logic [1:0] NA4   = 2'd2;
  localparam logic [1:0] NAPOT = 2'd3;

  localparam logic [2:0] BYTE  = 3'd0;
  localparam logic [2:0] HWORD = 3'd1;
  localparam logic [2:0] WORD  = 3'd2;
  localparam logic [2:0] DWORD = 3'd3;
  localparam logic [2:0] QWORD = 3'd4;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  typedef enum logic [1:0] {IDLE, CHECK, RESP} arb_state_t;

  // 14-bit PMA attribute word, MSB first
  typedef struct packed {
    logic [1:0] mem_type;
    logic       r;
    logic       w;
    logic       x;
    logic       c;
    logic       cc;
    logic       ri;
    logic       wi;
    logic       m;
    logic [1:0] amo_type;
    logic [1:0] a;
  } pma_cfg_t;

endpackage

// File: rtl/riscv_pmachk.sv
// rtl/riscv_pmachk.sv - combinational PMA region match and access permission check
module riscv_pmachk
  import riscv_mpsoc_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int PLEN    = 64,
  parameter int PMA_CNT = 4
) (
  input  logic [PMA_CNT-1:0][13:0]     pma_cfg_i,
  input  logic [PMA_CNT-1:0][XLEN-1:0] pma_adr_i,
  input  logic                         req_i,
  input  logic                         instruction_i,
  input  logic [PLEN-1:0]              adr_i,
  input  logic [2:0]                   size_i,
  input  logic                         lock_i,
  input  logic                         we_i,
  input  logic                         misaligned_i,
  output logic [13:0]                  pma_o,
  output logic                         exception_o,
  output logic                         misaligned_o,
  output logic                         is_cache_access_o,
  output logic                         is_ext_access_o,
  output logic                         is_tcm_access_o
);

  logic [XLEN-1:0]    w_adr4;
  logic [PMA_CNT-1:0] w_match;
  logic               w_hit;
  pma_cfg_t           w_cfg;
  logic               w_size_ok;
  logic               w_denied;
  logic               w_ok;

  assign w_adr4 = XLEN'(adr_i >> 2);

  for (genvar i = 0; i < PMA_CNT; i++) begin : g_match
    pma_cfg_t        w_c;
    logic [XLEN-1:0] w_lo;
    logic [XLEN-1:0] w_mask;
    logic            w_m;

    assign w_c    = pma_cfg_t'(pma_cfg_i[i]);
    assign w_mask = ~(pma_adr_i[i] ^ (pma_adr_i[i] + XLEN'(1)));
    if (i == 0) begin : g_lo0
      assign w_lo = '0;
    end else begin : g_lon
      assign w_lo = pma_adr_i[i-1];
    end

    always_comb begin
      w_m = 1'b0;
      case (w_c.a)
        OFF:     w_m = 1'b0;
        TOR:     w_m = (w_adr4 >= w_lo) && (w_adr4 < pma_adr_i[i]);
        NA4:     w_m = (w_adr4 == pma_adr_i[i]);
        NAPOT:   w_m = ((w_adr4 & w_mask) == (pma_adr_i[i] & w_mask));
        default: w_m = 1'b0;
      endcase
    end
    assign w_match[i] = w_m;
  end

  // lowest-numbered matching region wins
  always_comb begin
    w_hit = 1'b0;
    w_cfg = '0;
    for (int i = PMA_CNT - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit = 1'b1;
        w_cfg = pma_cfg_t'(pma_cfg_i[i]);
      end
    end
  end

  assign w_size_ok = size_i inside {BYTE, HWORD, WORD, DWORD, QWORD};
  assign w_denied  = !w_hit || (w_cfg.mem_type == MEM_TYPE_EMPTY) || !w_size_ok ||
                     (instruction_i ? !w_cfg.x : (we_i ? !w_cfg.w : !w_cfg.r)) ||
                     (lock_i && (w_cfg.amo_type == 2'b00));

  assign exception_o  = req_i & w_denied;
  assign misaligned_o = req_i & misaligned_i & !w_cfg.m;
  assign w_ok         = req_i & !w_denied & !misaligned_o;

  assign is_cache_access_o = w_ok & (w_cfg.mem_type == MEM_TYPE_MAIN) & w_cfg.c;
  assign is_tcm_access_o   = w_ok & (w_cfg.mem_type == MEM_TYPE_TCM);
  assign is_ext_access_o   = w_ok & ((w_cfg.mem_type == MEM_TYPE_IO) |
                                     ((w_cfg.mem_type == MEM_TYPE_MAIN) & !w_cfg.c));
  assign pma_o             = req_i ? w_cfg : '0;

endmodule

// File: rtl/riscv_pma_arbiter.sv
// rtl/riscv_pma_arbiter.sv - round-robin sharing of one PMA checker between IF and DM ports
module riscv_pma_arbiter
  import riscv_mpsoc_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int PLEN    = 64,
  parameter int PMA_CNT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PMA_CNT-1:0][13:0]     pma_cfg_i,
  input  logic [PMA_CNT-1:0][XLEN-1:0] pma_adr_i,
  input  logic                         if_req_i,
  input  logic [PLEN-1:0]              if_adr_i,
  input  logic [2:0]                   if_size_i,
  output logic                         if_ack_o,
  input  logic                         dm_req_i,
  input  logic [PLEN-1:0]              dm_adr_i,
  input  logic [2:0]                   dm_size_i,
  input  logic                         dm_lock_i,
  input  logic                         dm_we_i,
  input  logic                         dm_misaligned_i,
  output logic                         dm_ack_o,
  output logic                         if_rsp_valid_o,
  input  logic                         if_rsp_ready_i,
  output logic                         dm_rsp_valid_o,
  input  logic                         dm_rsp_ready_i,
  output logic [13:0]                  pma_o,
  output logic                         exception_o,
  output logic                         misaligned_o,
  output logic                         is_cache_access_o,
  output logic                         is_ext_access_o,
  output logic                         is_tcm_access_o
);

  arb_state_t      r_state, w_state_nxt;
  logic            r_last_grant, r_owner;
  logic [PLEN-1:0] r_adr;
  logic [2:0]      r_size;
  logic            r_we, r_lock, r_mis, r_instr;
  logic            r_if_rsp_valid, r_dm_rsp_valid;
  logic [13:0]     r_pma;
  logic            r_exc, r_misal, r_cache, r_ext, r_tcm;

  logic            w_owner_ready, w_arb_en, w_grant_if, w_grant_dm;
  logic [13:0]     w_pma;
  logic            w_exc, w_misal, w_cache, w_ext, w_tcm;

  assign w_owner_ready = (r_owner == PORT_IF) ? if_rsp_ready_i : dm_rsp_ready_i;
  assign w_arb_en      = (r_state == IDLE) || ((r_state == RESP) && w_owner_ready);
  // on a tie the port that did not win last time is granted
  assign w_grant_if    = w_arb_en && if_req_i && (!dm_req_i || (r_last_grant == PORT_DM));
  assign w_grant_dm    = w_arb_en && dm_req_i && (!if_req_i || (r_last_grant == PORT_IF));

  assign if_ack_o = w_grant_if;
  assign dm_ack_o = w_grant_dm;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant_if || w_grant_dm) w_state_nxt = CHECK;
      CHECK:   w_state_nxt = RESP;
      RESP:    if (w_owner_ready) w_state_nxt = (w_grant_if || w_grant_dm) ? CHECK : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant   <= PORT_DM;
      r_owner        <= PORT_IF;
      r_adr          <= '0;
      r_size         <= '0;
      r_we           <= 1'b0;
      r_lock         <= 1'b0;
      r_mis          <= 1'b0;
      r_instr        <= 1'b0;
      r_if_rsp_valid <= 1'b0;
      r_dm_rsp_valid <= 1'b0;
      r_pma          <= '0;
      r_exc          <= 1'b0;
      r_misal        <= 1'b0;
      r_cache        <= 1'b0;
      r_ext          <= 1'b0;
      r_tcm          <= 1'b0;
    end else begin
      if (w_grant_if) begin
        r_adr        <= if_adr_i;
        r_size       <= if_size_i;
        r_we         <= 1'b0;
        r_lock       <= 1'b0;
        r_mis        <= 1'b0;
        r_instr      <= 1'b1;
        r_owner      <= PORT_IF;
        r_last_grant <= PORT_IF;
      end else if (w_grant_dm) begin
        r_adr        <= dm_adr_i;
        r_size       <= dm_size_i;
        r_we         <= dm_we_i;
        r_lock       <= dm_lock_i;
        r_mis        <= dm_misaligned_i;
        r_instr      <= 1'b0;
        r_owner      <= PORT_DM;
        r_last_grant <= PORT_DM;
      end

      if (r_state == CHECK) begin
        r_pma   <= w_pma;
        r_exc   <= w_exc;
        r_misal <= w_misal;
        r_cache <= w_cache;
        r_ext   <= w_ext;
        r_tcm   <= w_tcm;
        if (r_owner == PORT_IF) r_if_rsp_valid <= 1'b1;
        else                    r_dm_rsp_valid <= 1'b1;
      end else if ((r_state == RESP) && w_owner_ready) begin
        if (r_owner == PORT_IF) r_if_rsp_valid <= 1'b0;
        else                    r_dm_rsp_valid <= 1'b0;
      end
    end
  end

  riscv_pmachk #(
    .XLEN    (XLEN),
    .PLEN    (PLEN),
    .PMA_CNT (PMA_CNT)
  ) u_pmachk (
    .pma_cfg_i         (pma_cfg_i),
    .pma_adr_i         (pma_adr_i),
    .req_i             (r_state == CHECK),
    .instruction_i     (r_instr),
    .adr_i             (r_adr),
    .size_i            (r_size),
    .lock_i            (r_lock),
    .we_i              (r_we),
    .misaligned_i      (r_mis),
    .pma_o             (w_pma),
    .exception_o       (w_exc),
    .misaligned_o      (w_misal),
    .is_cache_access_o (w_cache),
    .is_ext_access_o   (w_ext),
    .is_tcm_access_o   (w_tcm)
  );

  assign if_rsp_valid_o    = r_if_rsp_valid;
  assign dm_rsp_valid_o    = r_dm_rsp_valid;
  assign pma_o             = r_pma;
  assign exception_o       = r_exc;
  assign misaligned_o      = r_misal;
  assign is_cache_access_o = r_cache;
  assign is_ext_access_o   = r_ext;
  assign is_tcm_access_o   = r_tcm;

endmodule

// File: tb/tb_riscv_pma_arbiter.sv
// tb/tb_riscv_pma_arbiter.sv - directed self-checking bench for riscv_pma_arbiter
module tb_riscv_pma_arbiter;
  import riscv_mpsoc_pkg::*;

  logic             clk, rst;
  logic [3:0][13:0] pma_cfg;
  logic [3:0][63:0] pma_adr;
  logic             if_req, if_ack, if_rsp_valid, if_rsp_ready;
  logic [63:0]      if_adr, dm_adr;
  logic [2:0]       if_size, dm_size;
  logic             dm_req, dm_ack, dm_lock, dm_we, dm_mis, dm_rsp_valid, dm_rsp_ready;
  logic [13:0]      pma;
  logic             exc, misal, is_cache, is_ext, is_tcm;

  int n_cmp = 0;
  int n_fail = 0;

  // attribute word: mem_type, r, w, x, c, cc=0, ri=1, wi=1, m, amo=0, a
  function automatic logic [13:0] mk(logic [1:0] mt, logic r, logic w, logic x, logic c,
                                     logic m, logic [1:0] a);
    return {mt, r, w, x, c, 1'b0, 1'b1, 1'b1, m, 2'b00, a};
  endfunction

  logic [13:0] CFG_RX, CFG_TCM;

  riscv_pma_arbiter #(.XLEN(64), .PLEN(64), .PMA_CNT(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .pma_cfg_i         (pma_cfg),
    .pma_adr_i         (pma_adr),
    .if_req_i          (if_req),
    .if_adr_i          (if_adr),
    .if_size_i         (if_size),
    .if_ack_o          (if_ack),
    .dm_req_i          (dm_req),
    .dm_adr_i          (dm_adr),
    .dm_size_i         (dm_size),
    .dm_lock_i         (dm_lock),
    .dm_we_i           (dm_we),
    .dm_misaligned_i   (dm_mis),
    .dm_ack_o          (dm_ack),
    .if_rsp_valid_o    (if_rsp_valid),
    .if_rsp_ready_i    (if_rsp_ready),
    .dm_rsp_valid_o    (dm_rsp_valid),
    .dm_rsp_ready_i    (dm_rsp_ready),
    .pma_o             (pma),
    .exception_o       (exc),
    .misaligned_o      (misal),
    .is_cache_access_o (is_cache),
    .is_ext_access_o   (is_ext),
    .is_tcm_access_o   (is_tcm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // issue one request on a port and return in its response cycle (ack cycle + 2)
  task automatic issue(input logic dm, input logic [63:0] adr, input logic we, input logic mis);
    @(negedge clk);
    if (dm) begin dm_req = 1'b1; dm_adr = adr; dm_we = we; dm_mis = mis; dm_size = WORD; end
    else begin if_req = 1'b1; if_adr = adr; if_size = WORD; end
    @(negedge clk);
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic release_rsp(input logic dm);
    if (dm) dm_rsp_ready = 1'b1; else if_rsp_ready = 1'b1;
    @(negedge clk);
    dm_rsp_ready = 1'b0; if_rsp_ready = 1'b0; dm_we = 1'b0; dm_mis = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 0; dm_req = 0; if_adr = 0; dm_adr = 0; if_size = 0; dm_size = 0;
    dm_lock = 0; dm_we = 0; dm_mis = 0; if_rsp_ready = 0; dm_rsp_ready = 0;
    pma_cfg = '0; pma_adr = '0;
    pma_cfg[0] = CFG_RX;  pma_adr[0] = 64'h1FFF;
    pma_cfg[1] = CFG_TCM; pma_adr[1] = 64'h5FFF;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; #1;
    n_cmp++; if ({if_ack, dm_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks got=%b exp=00", {if_ack, dm_ack}); end
    n_cmp++; if ({if_rsp_valid, dm_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_valids got=%b exp=00", {if_rsp_valid, dm_rsp_valid}); end
    n_cmp++; if (pma !== 14'h0) begin n_fail++; $display("FAIL reset_pma got=%h exp=0", pma); end
    n_cmp++; if ({exc, misal, is_cache, is_ext, is_tcm} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=00000", {exc, misal, is_cache, is_ext, is_tcm}); end
  endtask

  task automatic test_single_if;
    @(negedge clk);
    if_req = 1'b1; if_adr = 64'h100; if_size = WORD; #1;
    n_cmp++; if ({if_ack, dm_ack} !== 2'b10) begin n_fail++; $display("FAIL single_if_ack got=%b exp=10", {if_ack, dm_ack}); end
    @(negedge clk);
    if_req = 1'b0; #1;
    n_cmp++; if (if_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_if_early_valid got=%b exp=0", if_rsp_valid); end
    @(negedge clk); #1;
    n_cmp++; if ({if_rsp_valid, dm_rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL single_if_valid got=%b exp=10", {if_rsp_valid, dm_rsp_valid}); end
    n_cmp++; if ({exc, is_cache, is_ext, is_tcm} !== 4'b0100) begin n_fail++; $display("FAIL single_if_flags got=%b exp=0100", {exc, is_cache, is_ext, is_tcm}); end
    n_cmp++; if (pma !== CFG_RX) begin n_fail++; $display("FAIL single_if_pma got=%h exp=%h", pma, CFG_RX); end
    if_rsp_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (if_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_if_drop got=%b exp=0", if_rsp_valid); end
    if_rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_v;
    do_reset;
    @(negedge clk);
    if_req = 1'b1; if_adr = 64'h100; dm_req = 1'b1; dm_adr = 64'h200; dm_we = 1'b0;
    if_rsp_ready = 1'b1; dm_rsp_ready = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      if (k == 7) begin if_req = 1'b0; dm_req = 1'b0; end
      #1;
      exp_v = {(k == 0 || k == 4), (k == 2 || k == 6), (k == 2 || k == 6), (k == 4 || k == 8)};
      n_cmp++;
      if ({if_ack, dm_ack, if_rsp_valid, dm_rsp_valid} !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d {if_ack,dm_ack,if_v,dm_v} got=%b exp=%b", k, {if_ack, dm_ack, if_rsp_valid, dm_rsp_valid}, exp_v);
      end
      @(negedge clk);
    end
    if_rsp_ready = 1'b0; dm_rsp_ready = 1'b0;
  endtask

  task automatic test_dm_nowrite;
    @(negedge clk);
    dm_req = 1'b1; dm_adr = 64'h200; dm_we = 1'b1; dm_size = DWORD; #1;
    n_cmp++; if ({if_ack, dm_ack} !== 2'b01) begin n_fail++; $display("FAIL nowrite_ack got=%b exp=01", {if_ack, dm_ack}); end
    @(negedge clk);
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if ({if_rsp_valid, dm_rsp_valid} !== 2'b01) begin n_fail++; $display("FAIL nowrite_valid got=%b exp=01", {if_rsp_valid, dm_rsp_valid}); end
    n_cmp++; if ({exc, is_cache, is_ext, is_tcm} !== 4'b1000) begin n_fail++; $display("FAIL nowrite_flags got=%b exp=1000", {exc, is_cache, is_ext, is_tcm}); end
    release_rsp(1'b1);
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    if_req = 1'b1; if_adr = 64'h100; #1;
    n_cmp++; if (if_ack !== 1'b1) begin n_fail++; $display("FAIL bp_if_ack got=%b exp=1", if_ack); end
    @(negedge clk);
    if_req = 1'b0; dm_req = 1'b1; dm_adr = 64'h200; dm_we = 1'b0; #1;
    n_cmp++; if ({if_ack, dm_ack} !== 2'b00) begin n_fail++; $display("FAIL bp_check_ack got=%b exp=00", {if_ack, dm_ack}); end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) pma_cfg[0] = 14'h0;
      dm_rsp_ready = 1'b1;
      #1;
      n_cmp++;
      if ({if_ack, dm_ack, if_rsp_valid, exc, is_cache} !== 5'b00101 || pma !== CFG_RX) begin
        n_fail++;
        $display("FAIL bp_hold%0d {if_ack,dm_ack,if_v,exc,cache} got=%b exp=00101 pma got=%h exp=%h", k, {if_ack, dm_ack, if_rsp_valid, exc, is_cache}, pma, CFG_RX);
      end
      @(negedge clk);
    end
    pma_cfg[0] = CFG_RX; dm_rsp_ready = 1'b0; if_rsp_ready = 1'b1; #1;
    n_cmp++; if ({if_ack, dm_ack} !== 2'b01) begin n_fail++; $display("FAIL bp_ready_ack got=%b exp=01", {if_ack, dm_ack}); end
    @(negedge clk);
    if_rsp_ready = 1'b0; dm_req = 1'b0; #1;
    n_cmp++; if ({if_rsp_valid, dm_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL bp_gap got=%b exp=00", {if_rsp_valid, dm_rsp_valid}); end
    @(negedge clk); #1;
    n_cmp++; if ({dm_rsp_valid, exc, is_cache} !== 3'b101) begin n_fail++; $display("FAIL bp_dm_rsp {dm_v,exc,cache} got=%b exp=101", {dm_rsp_valid, exc, is_cache}); end
    release_rsp(1'b1);
  endtask

  task automatic test_unmatched_io;
    issue(1'b0, 64'hFFFF_0000, 1'b0, 1'b0);
    n_cmp++; if ({if_rsp_valid, exc} !== 2'b11 || pma !== 14'h0) begin n_fail++; $display("FAIL unmatched {if_v,exc} got=%b exp=11 pma got=%h exp=0", {if_rsp_valid, exc}, pma); end
    release_rsp(1'b0);
    issue(1'b1, 64'h1_0004, 1'b0, 1'b1);
    n_cmp++; if ({dm_rsp_valid, exc, misal, is_tcm} !== 4'b1010) begin n_fail++; $display("FAIL tcm_misal {dm_v,exc,mis,tcm} got=%b exp=1010", {dm_rsp_valid, exc, misal, is_tcm}); end
    n_cmp++; if (pma !== CFG_TCM) begin n_fail++; $display("FAIL tcm_pma got=%h exp=%h", pma, CFG_TCM); end
    release_rsp(1'b1);
    issue(1'b1, 64'h1_0008, 1'b0, 1'b0);
    n_cmp++; if ({dm_rsp_valid, exc, misal, is_tcm, is_ext} !== 5'b10010) begin n_fail++; $display("FAIL tcm_ok {dm_v,exc,mis,tcm,ext} got=%b exp=10010", {dm_rsp_valid, exc, misal, is_tcm, is_ext}); end
    release_rsp(1'b1);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    dm_req = 1'b1; dm_adr = 64'h200; dm_we = 1'b0; dm_mis = 1'b0;
    @(negedge clk);
    dm_req = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if ({if_ack, dm_ack, if_rsp_valid, dm_rsp_valid} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_hs got=%b exp=0000", {if_ack, dm_ack, if_rsp_valid, dm_rsp_valid}); end
    n_cmp++; if (pma !== 14'h0 || {exc, misal, is_cache, is_ext, is_tcm} !== 5'b0) begin n_fail++; $display("FAIL rstmid_out pma got=%h exp=0 flags got=%b exp=00000", pma, {exc, misal, is_cache, is_ext, is_tcm}); end
    rst = 1'b0; dm_req = 1'b1; #1;
    n_cmp++; if ({if_ack, dm_ack} !== 2'b01) begin n_fail++; $display("FAIL rstmid_ack got=%b exp=01", {if_ack, dm_ack}); end
    @(negedge clk);
    dm_req = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (dm_rsp_valid !== 1'b1 || pma !== CFG_RX) begin n_fail++; $display("FAIL rstmid_rsp dm_v got=%b exp=1 pma got=%h exp=%h", dm_rsp_valid, pma, CFG_RX); end
    release_rsp(1'b1);
  endtask

  initial begin
    CFG_RX  = mk(MEM_TYPE_MAIN, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, NAPOT);
    CFG_TCM = mk(MEM_TYPE_TCM,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NAPOT);
    test_reset;
    test_single_if;
    test_back_to_back;
    test_dm_nowrite;
    test_backpressure;
    test_unmatched_io;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
